// File: rtl/exe_stage_if.sv
// Decode/execute/memory handshake, data-SRAM request and forwarding signals of the execute stage.
// master = execute stage side, slave = surrounding pipeline / environment side.
interface exe_stage_if;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [163:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [77:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [4:0]   es_to_ds_dest;
    logic [31:0]  es_to_ds_value;
    logic         es_value_from_mem;

    modport master (
        input  ms_allowin,
        input  ds_to_es_valid,
        input  ds_to_es_bus,
        output es_allowin,
        output es_to_ms_valid,
        output es_to_ms_bus,
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        output es_to_ds_dest,
        output es_to_ds_value,
        output es_value_from_mem
    );

    modport slave (
        output ms_allowin,
        output ds_to_es_valid,
        output ds_to_es_bus,
        input  es_allowin,
        input  es_to_ms_valid,
        input  es_to_ms_bus,
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        input  es_to_ds_dest,
        input  es_to_ds_value,
        input  es_value_from_mem
    );
endinterface

// File: rtl/exe_stage.sv
// LoongArch-32 execute stage: ALU, single-cycle multiplier, data-SRAM request and forwarding.
// Define EXE_DIV_EN to build the iterative radix-2 divider; otherwise div/mod return 0 in one cycle.
module exe_stage (
    input  logic        clk,
    input  logic        reset,
    exe_stage_if.master es_if
);
    logic         r_es_valid;
    logic [162:0] r_ds_to_es_bus;
    logic         w_es_ready_go;
    logic         w_es_allowin;
    logic         w_unused_bit;

    logic [7:0]   w_ld_st_op;
    logic [6:0]   w_mul_div_op;
    logic [31:0]  w_pc;
    logic [11:0]  w_alu_op;
    logic [31:0]  w_src1;
    logic [31:0]  w_src2;
    logic [31:0]  w_rkd;
    logic         w_res_from_mem;
    logic         w_mem_we;
    logic [4:0]   w_dest;
    logic         w_gr_we;

    assign {w_ld_st_op, w_mul_div_op, w_pc, w_alu_op, w_src1, w_src2,
            w_rkd, w_res_from_mem, w_mem_we, w_dest, w_gr_we} = r_ds_to_es_bus;
    assign w_unused_bit = es_if.ds_to_es_bus[163];

    assign w_es_allowin         = !r_es_valid || (w_es_ready_go && es_if.ms_allowin);
    assign es_if.es_allowin     = w_es_allowin;
    assign es_if.es_to_ms_valid = r_es_valid && w_es_ready_go;

    // Stage occupancy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_es_valid <= 1'b0;
        end else if (w_es_allowin) begin
            r_es_valid <= es_if.ds_to_es_valid;
        end else begin
            r_es_valid <= r_es_valid;
        end
    end

    // Decode-to-execute bus register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ds_to_es_bus <= 163'h0;
        end else if (es_if.ds_to_es_valid && w_es_allowin) begin
            r_ds_to_es_bus <= es_if.ds_to_es_bus[162:0];
        end else begin
            r_ds_to_es_bus <= r_ds_to_es_bus;
        end
    end

    // ---------------- ALU ----------------
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_sll;
    logic [31:0] w_srl;
    logic [31:0] w_sra;
    logic [31:0] w_alu_result;
    logic        w_slt;
    logic        w_sltu;
    logic [4:0]  w_sa;

    assign w_sa   = w_src2[4:0];
    assign w_sum  = w_src1 + w_src2;
    assign w_diff = w_src1 - w_src2;
    assign w_slt  = $signed(w_src1) < $signed(w_src2);
    assign w_sltu = w_src1 < w_src2;
    assign w_sll  = w_src1 << w_sa;
    assign w_srl  = w_src1 >> w_sa;
    // Kept as its own assignment so the arithmetic shift is not demoted by an unsigned context
    assign w_sra  = $signed(w_src1) >>> w_sa;

    assign w_alu_result = ({32{w_alu_op[0]}}  & w_sum)
                        | ({32{w_alu_op[1]}}  & w_diff)
                        | ({32{w_alu_op[2]}}  & {31'h0, w_slt})
                        | ({32{w_alu_op[3]}}  & {31'h0, w_sltu})
                        | ({32{w_alu_op[4]}}  & (w_src1 & w_src2))
                        | ({32{w_alu_op[5]}}  & ~(w_src1 | w_src2))
                        | ({32{w_alu_op[6]}}  & (w_src1 | w_src2))
                        | ({32{w_alu_op[7]}}  & (w_src1 ^ w_src2))
                        | ({32{w_alu_op[8]}}  & w_sll)
                        | ({32{w_alu_op[9]}}  & w_srl)
                        | ({32{w_alu_op[10]}} & w_sra)
                        | ({32{w_alu_op[11]}} & w_src2);

    // ---------------- Multiplier ----------------
    logic        w_mul_signed;
    logic [65:0] w_mul_a;
    logic [65:0] w_mul_b;
    logic [65:0] w_product;
    logic [31:0] w_mul_result;

    // Operands extended to the full product width so unsigned multiply yields the signed 33x33 product
    assign w_mul_signed = w_mul_div_op[0] | w_mul_div_op[1];
    assign w_mul_a      = {{34{w_mul_signed & w_src1[31]}}, w_src1};
    assign w_mul_b      = {{34{w_mul_signed & w_src2[31]}}, w_src2};
    assign w_product    = w_mul_a * w_mul_b;
    assign w_mul_result = w_mul_div_op[0] ? w_product[31:0] : w_product[63:32];

    // ---------------- Divider ----------------
    logic [31:0] w_div_result;

`ifdef EXE_DIV_EN
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    div_state_t  r_div_state;
    div_state_t  w_div_state_nxt;
    logic [4:0]  r_div_cnt;
    logic [31:0] r_div_quot;
    logic [31:0] r_div_rem;
    logic [31:0] r_div_dsr;
    logic        w_is_div;
    logic        w_div_signed;
    logic        w_is_mod;
    logic        w_neg1;
    logic        w_neg2;
    logic        w_div_start;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic [32:0] w_rem_shift;
    logic [32:0] w_trial;

    assign w_is_div     = |w_mul_div_op[6:3];
    assign w_div_signed = w_mul_div_op[3] | w_mul_div_op[4];
    assign w_is_mod     = w_mul_div_op[4] | w_mul_div_op[6];
    assign w_neg1       = w_div_signed & w_src1[31];
    assign w_neg2       = w_div_signed & w_src2[31];
    assign w_abs1       = w_neg1 ? (32'h0 - w_src1) : w_src1;
    assign w_abs2       = w_neg2 ? (32'h0 - w_src2) : w_src2;
    assign w_div_start  = (r_div_state == DIV_IDLE) && r_es_valid && w_is_div;

    // A negative trial difference (bit 32 set) means the divisor did not fit: restore
    assign w_rem_shift  = {r_div_rem, r_div_quot[31]};
    assign w_trial      = w_rem_shift - {1'b0, r_div_dsr};

    // Divider state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_state <= DIV_IDLE;
        end else begin
            r_div_state <= w_div_state_nxt;
        end
    end

    // Divider next-state logic
    always_comb begin
        w_div_state_nxt = r_div_state;
        case (r_div_state)
            DIV_IDLE: w_div_state_nxt = w_div_start ? DIV_RUN : DIV_IDLE;
            DIV_RUN:  w_div_state_nxt = (r_div_cnt == 5'd31) ? DIV_DONE : DIV_RUN;
            DIV_DONE: w_div_state_nxt = es_if.ms_allowin ? DIV_IDLE : DIV_DONE;
            default:  w_div_state_nxt = DIV_IDLE;
        endcase
    end

    // Divider datapath: operand load in IDLE, one restoring step per RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt  <= 5'd0;
            r_div_quot <= 32'h0;
            r_div_rem  <= 32'h0;
            r_div_dsr  <= 32'h0;
        end else if (w_div_start) begin
            r_div_cnt  <= 5'd0;
            r_div_quot <= w_abs1;
            r_div_rem  <= 32'h0;
            r_div_dsr  <= w_abs2;
        end else if (r_div_state == DIV_RUN) begin
            r_div_cnt  <= r_div_cnt + 5'd1;
            r_div_quot <= {r_div_quot[30:0], ~w_trial[32]};
            r_div_rem  <= w_trial[32] ? w_rem_shift[31:0] : w_trial[31:0];
            r_div_dsr  <= r_div_dsr;
        end else begin
            r_div_cnt  <= r_div_cnt;
            r_div_quot <= r_div_quot;
            r_div_rem  <= r_div_rem;
            r_div_dsr  <= r_div_dsr;
        end
    end

    assign w_quot_fix    = (w_neg1 ^ w_neg2) ? (32'h0 - r_div_quot) : r_div_quot;
    assign w_rem_fix     = w_neg1 ? (32'h0 - r_div_rem) : r_div_rem;
    assign w_div_result  = (w_src2 == 32'h0) ? (w_is_mod ? w_src1 : 32'hFFFF_FFFF)
                                             : (w_is_mod ? w_rem_fix : w_quot_fix);
    assign w_es_ready_go = !w_is_div || (r_div_state == DIV_DONE);
`else
    assign w_div_result  = 32'h0;
    assign w_es_ready_go = 1'b1;
`endif

    // ---------------- Result select ----------------
    logic [31:0] w_es_result;

    assign w_es_result = (|w_mul_div_op)
                       ? ((|w_mul_div_op[2:0]) ? w_mul_result : w_div_result)
                       : w_alu_result;

    // ---------------- Data SRAM request ----------------
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;

    // Byte-lane strobes and replicated store data per store width
    always_comb begin
        w_strb  = 4'b0000;
        w_wdata = w_rkd;
        if (w_ld_st_op[5]) begin
            w_strb  = 4'b0001 << w_sum[1:0];
            w_wdata = {4{w_rkd[7:0]}};
        end else if (w_ld_st_op[6]) begin
            w_strb  = 4'b0011 << {w_sum[1], 1'b0};
            w_wdata = {2{w_rkd[15:0]}};
        end else if (w_ld_st_op[7]) begin
            w_strb  = 4'b1111;
            w_wdata = w_rkd;
        end else begin
            w_strb  = 4'b0000;
            w_wdata = w_rkd;
        end
    end

    assign es_if.data_sram_en    = r_es_valid && (w_res_from_mem || w_mem_we) && es_if.ms_allowin;
    assign es_if.data_sram_we    = (r_es_valid && w_mem_we) ? w_strb : 4'b0000;
    assign es_if.data_sram_addr  = w_sum;
    assign es_if.data_sram_wdata = w_wdata;

    // ---------------- Memory-stage bus and forwarding ----------------
    assign es_if.es_to_ms_bus      = {w_ld_st_op[4:0], w_sum[1:0], w_res_from_mem,
                                      w_gr_we, w_dest, w_es_result, w_pc};
    assign es_if.es_to_ds_dest     = (r_es_valid && w_gr_we) ? w_dest : 5'd0;
    assign es_if.es_to_ds_value    = w_es_result;
    assign es_if.es_value_from_mem = r_es_valid && w_res_from_mem;
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: stimulus pushes expected memory-stage bus words,
// a negedge monitor pops and compares each transfer. Divider expectations follow EXE_DIV_EN.
module tb_exe_stage;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [77:0] exp_q[$];

    localparam logic [11:0] A_ADD  = 12'h001;
    localparam logic [11:0] A_SUB  = 12'h002;
    localparam logic [11:0] A_SLT  = 12'h004;
    localparam logic [11:0] A_SLTU = 12'h008;
    localparam logic [11:0] A_AND  = 12'h010;
    localparam logic [11:0] A_NOR  = 12'h020;
    localparam logic [11:0] A_OR   = 12'h040;
    localparam logic [11:0] A_XOR  = 12'h080;
    localparam logic [11:0] A_SLL  = 12'h100;
    localparam logic [11:0] A_SRL  = 12'h200;
    localparam logic [11:0] A_SRA  = 12'h400;
    localparam logic [11:0] A_LUI  = 12'h800;
    localparam logic [6:0]  M_MUL   = 7'h01;
    localparam logic [6:0]  M_MULH  = 7'h02;
    localparam logic [6:0]  M_MULHU = 7'h04;
    localparam logic [6:0]  M_DIV   = 7'h08;
    localparam logic [6:0]  M_MOD   = 7'h10;
    localparam logic [6:0]  M_DIVU  = 7'h20;
    localparam logic [6:0]  M_MODU  = 7'h40;
    localparam logic [7:0]  L_LDW  = 8'h10;
    localparam logic [7:0]  S_STB  = 8'h20;
    localparam logic [7:0]  S_STH  = 8'h40;

`ifdef EXE_DIV_EN
    localparam int DIV_STALL = 33;
`else
    localparam int DIV_STALL = 0;
`endif

    exe_stage_if u_if ();

    exe_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .es_if (u_if)
    );

    always #5 clk = ~clk;

    function automatic logic [163:0] mk(input logic [7:0] ls, input logic [6:0] md,
                                        input logic [31:0] pc, input logic [11:0] alu,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [31:0] rkd, input logic rfm,
                                        input logic we, input logic [4:0] dest,
                                        input logic grwe);
        mk = {1'b0, ls, md, pc, alu, s1, s2, rkd, rfm, we, dest, grwe};
    endfunction

    task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [77:0] exp_bus(input logic [163:0] b, input logic [31:0] res,
                                            input logic [1:0] alo);
        exp_bus = {b[159:155], alo, b[7], b[0], b[5:1], res, b[147:116]};
    endfunction

    // Monitor: every transfer to the memory stage is matched against the scoreboard
    always @(negedge clk) begin
        if (reset === 1'b0 && u_if.es_to_ms_valid === 1'b1 && u_if.ms_allowin === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ms_bus_unexpected: got %h expected no transfer", u_if.es_to_ms_bus);
            end else begin
                chk("ms_bus", u_if.es_to_ms_bus, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [163:0] b);
        @(posedge clk);
        #1;
        u_if.ds_to_es_valid = 1'b1;
        u_if.ds_to_es_bus   = b;
        @(negedge clk);
        for (int n = 0; n < 100 && !u_if.es_allowin; n++) @(negedge clk);
        if (!u_if.es_allowin) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got es_allowin=0 expected 1");
        end
        @(posedge clk);
        #1;
        u_if.ds_to_es_valid = 1'b0;
    endtask

    task automatic exec(input string name, input logic [163:0] b, input logic [31:0] res,
                        input logic [1:0] alo);
        exp_q.push_back(exp_bus(b, res, alo));
        send(b);
        @(negedge clk);
        chk({name, "_valid"}, u_if.es_to_ms_valid, 78'd1);
        chk({name, "_fwd_value"}, u_if.es_to_ds_value, res);
        chk({name, "_fwd_dest"}, u_if.es_to_ds_dest, b[0] ? b[5:1] : 5'd0);
    endtask

    task automatic div_run(input string name, input logic [163:0] b, input logic [31:0] res,
                           input logic [1:0] alo);
        int cnt;
        cnt = 0;
        exp_q.push_back(exp_bus(b, res, alo));
        send(b);
        @(negedge clk);
        for (int n = 0; n < 60 && !u_if.es_allowin; n++) begin
            cnt++;
            @(negedge clk);
        end
        chk({name, "_stall_cycles"}, cnt, DIV_STALL);
        chk({name, "_fwd_value"}, u_if.es_to_ds_value, res);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [163:0] b;
        logic [77:0]  stall_exp;

        reset               = 1'b1;
        u_if.ms_allowin     = 1'b1;
        u_if.ds_to_es_valid = 1'b0;
        u_if.ds_to_es_bus   = 164'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("rst_es_to_ms_valid", u_if.es_to_ms_valid, 78'd0);
        chk("rst_es_allowin", u_if.es_allowin, 78'd1);
        chk("rst_sram_en", u_if.data_sram_en, 78'd0);
        chk("rst_sram_we", u_if.data_sram_we, 78'd0);
        chk("rst_fwd_dest", u_if.es_to_ds_dest, 78'd0);
        chk("rst_value_from_mem", u_if.es_value_from_mem, 78'd0);

        // ALU vectors
        exec("add",  mk(8'h0, 7'h0, 32'h1c000000, A_ADD,  32'd5, 32'd7, 32'h0, 1'b0, 1'b0, 5'd5, 1'b1), 32'd12, 2'b00);
        exec("sub",  mk(8'h0, 7'h0, 32'h1c000004, A_SUB,  32'd5, 32'd7, 32'h0, 1'b0, 1'b0, 5'd6, 1'b1), 32'hFFFFFFFE, 2'b00);
        exec("slt",  mk(8'h0, 7'h0, 32'h1c000008, A_SLT,  32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 1'b0, 5'd7, 1'b1), 32'd1, 2'b00);
        exec("sltu", mk(8'h0, 7'h0, 32'h1c00000c, A_SLTU, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 1'b0, 5'd8, 1'b1), 32'd0, 2'b00);
        exec("and",  mk(8'h0, 7'h0, 32'h1c000010, A_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 1'b0, 1'b0, 5'd9, 1'b1), 32'hF000F000, 2'b00);
        exec("nor",  mk(8'h0, 7'h0, 32'h1c000014, A_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 1'b0, 1'b0, 5'd10, 1'b1), 32'h000F000F, 2'b00);
        exec("or",   mk(8'h0, 7'h0, 32'h1c000018, A_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 1'b0, 1'b0, 5'd11, 1'b1), 32'hFFF0FFF0, 2'b00);
        exec("xor",  mk(8'h0, 7'h0, 32'h1c00001c, A_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 1'b0, 1'b0, 5'd12, 1'b1), 32'h0FF00FF0, 2'b00);
        exec("sll",  mk(8'h0, 7'h0, 32'h1c000020, A_SLL,  32'h00000001, 32'h0000003F, 32'h0, 1'b0, 1'b0, 5'd13, 1'b1), 32'h80000000, 2'b00);
        exec("srl",  mk(8'h0, 7'h0, 32'h1c000024, A_SRL,  32'h80000000, 32'd4, 32'h0, 1'b0, 1'b0, 5'd14, 1'b1), 32'h08000000, 2'b00);
        exec("sra",  mk(8'h0, 7'h0, 32'h1c000028, A_SRA,  32'h80000000, 32'd4, 32'h0, 1'b0, 1'b0, 5'd15, 1'b1), 32'hF8000000, 2'b00);
        exec("lui",  mk(8'h0, 7'h0, 32'h1c00002c, A_LUI,  32'h0, 32'h12345000, 32'h0, 1'b0, 1'b0, 5'd16, 1'b1), 32'h12345000, 2'b00);

        // Multiplier
        exec("mul_w",   mk(8'h0, M_MUL,   32'h1c000030, 12'h0, 32'hFFFFFFFD, 32'd5, 32'h0, 1'b0, 1'b0, 5'd17, 1'b1), 32'hFFFFFFF1, 2'b10);
        exec("mulh_w",  mk(8'h0, M_MULH,  32'h1c000034, 12'h0, 32'h80000000, 32'd2, 32'h0, 1'b0, 1'b0, 5'd18, 1'b1), 32'hFFFFFFFF, 2'b10);
        exec("mulh_wu", mk(8'h0, M_MULHU, 32'h1c000038, 12'h0, 32'h80000000, 32'd2, 32'h0, 1'b0, 1'b0, 5'd19, 1'b1), 32'h00000001, 2'b10);

        // Divider (results are 0 when the divider is not built)
`ifdef EXE_DIV_EN
        div_run("div_w",  mk(8'h0, M_DIV,  32'h1c00003c, 12'h0, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 1'b0, 5'd20, 1'b1), 32'hFFFFFFFD, 2'b11);
        div_run("mod_w",  mk(8'h0, M_MOD,  32'h1c000040, 12'h0, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 1'b0, 5'd21, 1'b1), 32'hFFFFFFFF, 2'b11);
        div_run("div_wu0", mk(8'h0, M_DIVU, 32'h1c000044, 12'h0, 32'd100, 32'd0, 32'h0, 1'b0, 1'b0, 5'd22, 1'b1), 32'hFFFFFFFF, 2'b00);
        div_run("mod_wu0", mk(8'h0, M_MODU, 32'h1c000048, 12'h0, 32'd100, 32'd0, 32'h0, 1'b0, 1'b0, 5'd23, 1'b1), 32'd100, 2'b00);
        div_run("div_ovf", mk(8'h0, M_DIV,  32'h1c00004c, 12'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 5'd24, 1'b1), 32'h80000000, 2'b11);
        // Division interrupted by reset is dropped: nothing goes on the scoreboard
        send(mk(8'h0, M_DIVU, 32'h1c000050, 12'h0, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 5'd25, 1'b1));
        repeat (11) @(posedge clk);
`else
        div_run("div_w",  mk(8'h0, M_DIV,  32'h1c00003c, 12'h0, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 1'b0, 5'd20, 1'b1), 32'h0, 2'b11);
        div_run("mod_w",  mk(8'h0, M_MOD,  32'h1c000040, 12'h0, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 1'b0, 5'd21, 1'b1), 32'h0, 2'b11);
        div_run("div_wu0", mk(8'h0, M_DIVU, 32'h1c000044, 12'h0, 32'd100, 32'd0, 32'h0, 1'b0, 1'b0, 5'd22, 1'b1), 32'h0, 2'b00);
        div_run("mod_wu0", mk(8'h0, M_MODU, 32'h1c000048, 12'h0, 32'd100, 32'd0, 32'h0, 1'b0, 1'b0, 5'd23, 1'b1), 32'h0, 2'b00);
        @(posedge clk);
`endif
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_es_to_ms_valid", u_if.es_to_ms_valid, 78'd0);
            chk("rst_mid_es_allowin", u_if.es_allowin, 78'd1);
        end

        // st_b to 0x1003
        b = mk(S_STB, 7'h0, 32'h1c000060, A_ADD, 32'h00001000, 32'd3, 32'h000000AB, 1'b0, 1'b1, 5'd0, 1'b0);
        exec("st_b", b, 32'h00001003, 2'b11);
        chk("st_b_sram_en", u_if.data_sram_en, 78'd1);
        chk("st_b_sram_we", u_if.data_sram_we, 78'b1000);
        chk("st_b_sram_wdata", u_if.data_sram_wdata, 32'hABABABAB);
        chk("st_b_sram_addr", u_if.data_sram_addr, 32'h00001003);

        // st_h held by memory-stage backpressure, then released
        @(posedge clk);
        #1;
        u_if.ms_allowin = 1'b0;
        b = mk(S_STH, 7'h0, 32'h1c000064, A_ADD, 32'h00002000, 32'd2, 32'h1234CDEF, 1'b0, 1'b1, 5'd0, 1'b0);
        stall_exp = exp_bus(b, 32'h00002002, 2'b10);
        exp_q.push_back(stall_exp);
        send(b);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", u_if.es_to_ms_valid, 78'd1);
            chk("stall_bus_stable", u_if.es_to_ms_bus, stall_exp);
            chk("stall_sram_en", u_if.data_sram_en, 78'd0);
            chk("stall_es_allowin", u_if.es_allowin, 78'd0);
        end
        @(posedge clk);
        #1;
        u_if.ms_allowin = 1'b1;
        @(negedge clk);
        chk("st_h_sram_en", u_if.data_sram_en, 78'd1);
        chk("st_h_sram_we", u_if.data_sram_we, 78'b1100);
        chk("st_h_sram_wdata", u_if.data_sram_wdata, 32'hCDEFCDEF);

        // ld_w to r4, then a bubble
        b = mk(L_LDW, 7'h0, 32'h1c000068, A_ADD, 32'h00002000, 32'd8, 32'h0, 1'b1, 1'b0, 5'd4, 1'b1);
        exec("ld_w", b, 32'h00002008, 2'b00);
        chk("ld_w_value_from_mem", u_if.es_value_from_mem, 78'd1);
        chk("ld_w_sram_en", u_if.data_sram_en, 78'd1);
        chk("ld_w_sram_we", u_if.data_sram_we, 78'd0);
        @(negedge clk);
        chk("bubble_fwd_dest", u_if.es_to_ds_dest, 78'd0);
        chk("bubble_value_from_mem", u_if.es_value_from_mem, 78'd0);
        chk("bubble_valid", u_if.es_to_ms_valid, 78'd0);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 78'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage LoongArch-32 pipeline, between decode and memory. It latches the decode-to-execute bus and computes the ALU result. Multiplies complete in one cycle. Divide and modulo run on an iterative radix-2 divider that stalls the stage. The stage issues the data-SRAM request for loads and stores and drives the forwarding and load-use interlock signals back to decode.

## Interface
- No parameters.
- `clk` in 1: clock.
- `reset` in 1: reset. Synchronous, active-high.
- `ms_allowin` in 1: memory stage can accept.
- `es_allowin` out 1: execute stage can accept.
- `ds_to_es_valid` in 1: decode bus valid.
- `ds_to_es_bus` in 164: `[162:155]` ld_st_op (ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w); `[154:148]` mul_div_op (mul_w, mulh_w, mulh_wu, div_w, mod_w, div_wu, mod_wu); `[147:116]` pc; `[115:104]` alu_op; `[103:72]` src1; `[71:40]` src2; `[39:8]` rkd_value; `[7]` res_from_mem; `[6]` mem_we; `[5:1]` dest; `[0]` gr_we; `[163]` reserved and ignored.
- `es_to_ms_valid` out 1: memory-stage bus valid.
- `es_to_ms_bus` out 78: `[31:0]` pc; `[63:32]` result; `[68:64]` dest; `[69]` gr_we; `[70]` res_from_mem; `[72:71]` addr[1:0]; `[77:73]` load op (ld_b..ld_w).
- `data_sram_en` out 1: SRAM request.
- `data_sram_we` out 4: byte write strobes.
- `data_sram_addr` out 32: byte address.
- `data_sram_wdata` out 32: store data.
- `es_to_ds_dest` out 5: destination register, 0 when there is none.
- `es_to_ds_value` out 32: forwarded result.
- `es_value_from_mem` out 1: the instruction in execute is a load.

## Operation
**Handshake**
- `es_allowin = !es_valid || (es_ready_go && ms_allowin)`.
- `es_to_ms_valid = es_valid && es_ready_go`.
- The bus register loads when `ds_to_es_valid && es_allowin`. `es_valid` takes `ds_to_es_valid` whenever `es_allowin` is high.

**ALU**
- alu_op is one-hot. Bits 0-11 select: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- Shift amount is src2[4:0].
- lui result is src2.

**Multiplier**
- Combinational 33x33 signed product of sign- or zero-extended operands.
- mul_w returns product[31:0].
- mulh_w and mulh_wu return product[63:32].
- `es_ready_go = 1`.

**Divider FSM**
- States are DIV_IDLE, DIV_RUN and DIV_DONE.
- In IDLE with `es_valid` and a div/mod op:
  - latch |src1| and |src2| (absolute values for signed ops, raw values for unsigned ops);
  - clear the counter;
  - go to RUN.
- In RUN, each cycle produces one restoring step (one quotient bit). After 32 steps, go to DONE.
- In DONE:
  - `es_ready_go = 1`;
  - the sign fixup is applied: the quotient is negated when the operand signs differ, and the remainder takes the sign of the dividend;
  - when `ms_allowin` is high the instruction leaves and the FSM returns to IDLE.
- `es_ready_go = 0` in IDLE and RUN for div/mod ops.
- Divisor zero returns quotient 32'hFFFFFFFF and remainder = src1, regardless of signedness.
- 32'h80000000 / -1 (div_w) returns quotient 32'h80000000 and remainder 0.

**Result select**
- mul_div_op nonzero selects the mul/div result; otherwise the ALU result is used.

**Memory**
- Address is the ALU sum.
- `data_sram_en = es_valid && (res_from_mem || mem_we) && ms_allowin`.
- Write strobes:
  - st_b: 4'b0001 shifted left by addr[1:0];
  - st_h: 4'b0011 shifted left by {addr[1],1'b0};
  - st_w: 4'b1111.
- Strobes are forced to 0 unless `mem_we` is set.
- Store data is replicated:
  - st_b: {4{rkd[7:0]}};
  - st_h: {2{rkd[15:0]}};
  - st_w: rkd.
- Misaligned addresses are not checked.

**Forwarding**
- `es_to_ds_dest = (es_valid && gr_we) ? dest : 0`.
- `es_to_ds_value` = the selected result.
- `es_value_from_mem = es_valid && res_from_mem`.

## Timing
- **Reset values:**
  - `es_valid` = 0, so `es_to_ms_valid` = 0 and `es_allowin` = 1;
  - `data_sram_en` = 0 and `data_sram_we` = 0;
  - `es_to_ds_dest` = 0 and `es_value_from_mem` = 0;
  - divider goes to IDLE.
- **Latency:**
  - non-divide instructions: 1 cycle in the stage;
  - divide/modulo: 34 cycles (1 IDLE load, 32 RUN, 1 DONE) when `ms_allowin` is held high.
- **Backpressure in DONE:** if `ms_allowin` is low, the FSM stays in DONE and the result and outputs stay stable.
- **Reset mid-division:** the FSM returns to IDLE and the instruction is dropped.
- **Back-to-back divides:** a new divide enters in the cycle the old one leaves. The next cycle starts from IDLE.
- **Memory requests:** the SRAM request is issued in the same cycle the instruction transfers to the memory stage. Read data returns one cycle later, inside the memory stage.

## Configuration
- `EXE_DIV_EN` defined: the iterative divider is built as specified above.
- `EXE_DIV_EN` undefined:
  - div/mod ops complete in 1 cycle with result 32'h0;
  - the divider FSM and registers are removed;
  - `es_ready_go` is always 1.

## Test plan
- add with src1=5 and src2=7, `ms_allowin`=1: `es_to_ms_valid` 1 cycle after entry with result 12; `es_to_ds_dest` = dest while valid.
- div_w with src1=-7 and src2=2: `es_allowin` low for 33 cycles, then result 32'hFFFFFFFD; mod_w on the same operands gives 32'hFFFFFFFF.
- div_wu with src1=100 and src2=0: result 32'hFFFFFFFF; mod_wu gives 100. Also assert reset at RUN step 10: the FSM returns to IDLE and `es_to_ms_valid` stays 0.
- st_b to address 0x1003 with rkd=0xAB: `data_sram_we`=4'b1000 and `data_sram_wdata`=0xABABABAB. With `ms_allowin`=0 the `data_sram_en` output stays 0.
- ld_w with dest r4: `es_value_from_mem`=1 and `es_to_ds_dest`=4. A bubble gives `es_to_ds_dest`=0.
- mulh_w with 0x80000000 * 2 gives 32'hFFFFFFFF; mulh_wu with the same operands gives 1. Holding `ms_allowin`=0 in DONE keeps the result stable for 5 cycles.
